pcount_acq_ctrl: RTL and testbench
==================================

# pcount_acq_ctrl

Acquisition controller for the four-channel pulse counter. It opens a bounded acquisition window by driving the counter enable, and detects each rising edge of the counter's trigger. On each edge it captures the 8-bit latch word, tags it with a window-relative timestamp, buffers it in a small FIFO and presents it to a downstream reader over a valid/ready handshake. It sits between the pulse counter and the readout/host interface logic.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- TS_W, 16: timestamp and window-length width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms a new window; honoured only in IDLE.
- stop  in  1  one-cycle pulse; ends the window early; honoured in ARM and RUN.
- window_len  in  TS_W  window length in cycles; 0 means unlimited (ends only on stop); sampled in ARM.
- ctr_en  out  1  enable to the pulse counter; high only in RUN.
- trig_in  in  1  trigger from the pulse counter.
- latch_in  in  8  latch word from the pulse counter; must be stable in the first cycle trig_in reads high.
- evt_data  out  TS_W+8  {timestamp, latch word} at the FIFO head.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  reader accepts evt_data when valid and ready are both high.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse on the DRAIN to IDLE transition.
- drop_cnt  out  8  events lost to a full FIFO in the current window; saturates at 255.

## Operation
States: IDLE, ARM, RUN, DRAIN.

- IDLE:
  - ctr_en=0; no captures.
  - start moves to ARM.
- ARM (1 cycle):
  - Clears the FIFO, timestamp and drop_cnt.
  - Latches window_len.
  - Moves to RUN, or to DRAIN if stop is high.
- RUN:
  - ctr_en=1; the timestamp increments every cycle starting at 0.
  - Edge: trig_in=1 and trig_q=0, where trig_q is trig_in registered one cycle and cleared in ARM.
  - Each edge pushes {timestamp, latch_in}.
  - Exit to DRAIN on stop, or when window_len≠0 and timestamp==window_len-1. An edge in that final cycle is still captured.
  - With window_len=0 the timestamp wraps modulo 2^TS_W.
- DRAIN:
  - ctr_en=0; no captures.
  - Moves to IDLE with done=1 in the cycle after the FIFO becomes empty.
- Full FIFO:
  - A push on a full FIFO is dropped and drop_cnt increments, unless a pop occurs in the same cycle. A simultaneous pop and push on a full FIFO is accepted and the FIFO stays full.
- Empty FIFO: a simultaneous push and pop cannot occur, because evt_valid=0.
- Handshake: evt_data is held constant while evt_valid=1 and evt_ready=0.
- Commands outside their states: start outside IDLE and stop in IDLE/DRAIN are ignored.
- Reset: asynchronous reset at any point returns the block to IDLE. The FIFO is emptied and all registers are cleared.

## Timing
- Reset values: ctr_en=0, evt_valid=0, evt_data=0, busy=0, done=0, drop_cnt=0.
- Start sequence: start at cycle N gives ARM at N+1, then RUN with ctr_en=1 at N+2, and timestamp 0 at N+2.
- Window length: with window_len=L, RUN lasts exactly L cycles (timestamps 0..L-1).
- Capture latency: an edge at cycle M makes evt_valid=1 at M+1 when the FIFO was empty.
- Throughput: one push and one pop per cycle.
- Stop latency: stop in RUN at cycle M puts the block in DRAIN at M+1 with ctr_en=0.

## Structure
- Package pcount_pkg holds:
  - the state enum (IDLE, ARM, RUN, DRAIN);
  - EVT_LATCH_W=8;
  - the event word width function TS_W+8;
  - DROP_MAX=255.
- Sub-module pcount_evt_fifo: synchronous show-ahead FIFO with parameters DEPTH and width, a full/empty pair, and a synchronous clear input driven in ARM.
- The FSM, timestamp counter, edge detector and drop counter live in the top level.

## Test plan
- Basic window: window_len=10 and start, with trig_in edges at timestamps 2 and 7 carrying latch_in=8'h81 and 8'h12, and evt_ready=1. Expect events {2,81} and {7,12}, ctr_en high for exactly 10 cycles, then done, busy=0 and drop_cnt=0.
- Overflow: DEPTH=8, evt_ready=0, window_len=0, 11 edges, then stop. Expect 8 events retained in order and drop_cnt=3. Raising ready then drains all 8, followed by done.
- Full-FIFO simultaneous push and pop: FIFO full, evt_ready=1 and an edge in the same cycle. Expect the push accepted, drop_cnt unchanged and the FIFO still full.
- Held trigger: trig_in high for 5 cycles. Expect exactly 1 event. start pulses during RUN are ignored and the timestamp does not restart.
- Early stop: window_len=100, stop at timestamp 20. Expect ctr_en low the next cycle, no captures for later edges, and done after the last pop.
- Reset mid-operation: assert rst_n=0 in RUN with 3 queued events. Expect immediately ctr_en=0, evt_valid=0, busy=0 and drop_cnt=0. After release, a new start produces timestamps from 0.

Source files
------------

// File: rtl/pcount_pkg.sv
// Shared types and constants for the pulse-counter acquisition controller.
// Latency: n/a (types, constants and one width helper only).
// Backpressure: n/a.
package pcount_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int EVT_LATCH_W = 8;
  localparam int DROP_MAX    = 255;

  // Event word is {timestamp, latch word}.
  function automatic int evt_w(input int ts_w);
    return ts_w + EVT_LATCH_W;
  endfunction

endpackage

// File: rtl/pcount_evt_fifo.sv
// Show-ahead event FIFO: head word is visible on pop_data whenever empty=0.
// Latency: a push is visible at the head one cycle later; a pop frees an entry in the same cycle.
// Backpressure: a push is refused when full, unless a pop happens in the same cycle.
// Ports: clk/rst_n, clr (synchronous flush), push/push_data, pop/pop_data, full/empty.
module pcount_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              do_pop;
  logic              do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is not reset; the head is forced to zero while empty instead.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pcount_acq_ctrl.sv
// Acquisition controller: opens a counter window, timestamps trigger edges, queues latch words.
// Latency: trigger edge at cycle M shows as evt_valid at M+1 (empty FIFO); stop takes effect next cycle.
// Backpressure: evt_valid/evt_ready; edges that meet a full FIFO without a same-cycle pop are dropped and counted.
// Ports: start/stop/window_len control, ctr_en to the counter, trig_in/latch_in from it,
//        evt_data/evt_valid/evt_ready to the reader, busy/done/drop_cnt status.
module pcount_acq_ctrl
  import pcount_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic [TS_W-1:0]             window_len,
  output logic                        ctr_en,
  input  logic                        trig_in,
  input  logic [EVT_LATCH_W-1:0]      latch_in,
  output logic [TS_W+EVT_LATCH_W-1:0] evt_data,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  drop_cnt
);

  state_t          state;
  state_t          state_nxt;
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] win_len_q;
  logic            trig_q;
  logic            trig_edge;
  logic            win_end;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_clr;

  assign ctr_en    = (state == ST_RUN);
  assign busy      = (state != ST_IDLE);
  assign evt_valid = !fifo_empty;
  assign fifo_clr  = (state == ST_ARM);
  assign trig_edge = (state == ST_RUN) && trig_in && !trig_q;
  // A zero length never matches, so an unlimited window just lets ts wrap.
  assign win_end   = (win_len_q != '0) && (ts == win_len_q - TS_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ARM;
      ST_ARM:   state_nxt = stop ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (stop || win_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ts        <= '0;
      win_len_q <= '0;
      trig_q    <= 1'b0;
      drop_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      state  <= state_nxt;
      done   <= (state == ST_DRAIN) && fifo_empty;
      // Cleared in ARM so a trigger already high when RUN begins counts as an edge.
      trig_q <= (state == ST_ARM) ? 1'b0 : trig_in;
      if (state == ST_ARM) begin
        ts        <= '0;
        win_len_q <= window_len;
        drop_cnt  <= '0;
      end else if (state == ST_RUN) begin
        ts <= ts + TS_W'(1);
        // Full implies non-empty, so evt_ready alone means a pop frees the slot.
        if (trig_edge && fifo_full && !evt_ready && (drop_cnt != 8'(DROP_MAX)))
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  pcount_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (evt_w(TS_W))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (fifo_clr),
    .push      (trig_edge),
    .push_data ({ts, latch_in}),
    .pop       (evt_ready),
    .pop_data  (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pcount_acq_ctrl.sv
// Directed bench for pcount_acq_ctrl with DEPTH=8, TS_W=16.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each scenario task checks its own expected values inline.
module tb_pcount_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] window_len = '0;
  logic        ctr_en;
  logic        trig_in = 1'b0;
  logic [7:0]  latch_in = '0;
  logic [23:0] evt_data;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pcount_acq_ctrl #(.DEPTH(8), .TS_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .window_len (window_len),
    .ctr_en     (ctr_en),
    .trig_in    (trig_in),
    .latch_in   (latch_in),
    .evt_data   (evt_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .busy       (busy),
    .done       (done),
    .drop_cnt   (drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start and returns in the first RUN cycle (timestamp 0).
  task automatic go(input logic [15:0] len);
    window_len = len;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ctr_en !== 1'b0)    begin bad++; $display("FAIL reset_ctr_en got=%h exp=0", ctr_en); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_evt_valid got=%h exp=0", evt_valid); end
    total++; if (evt_data !== 24'h0) begin bad++; $display("FAIL reset_evt_data got=%h exp=0", evt_data); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%h exp=0", done); end
    total++; if (drop_cnt !== 8'h0)  begin bad++; $display("FAIL reset_drop_cnt got=%h exp=0", drop_cnt); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [23:0] got[$];
    int c = 0;
    int en_cnt = 0;
    bit seen = 0;
    logic busy_at_done = 1'bx;
    evt_ready = 1'b1;
    window_len = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b1 || ctr_en !== 1'b0) begin bad++; $display("FAIL basic_arm busy=%h ctr_en=%h exp busy=1 ctr_en=0", busy, ctr_en); end
    step();
    while (!seen && c < 40) begin
      trig_in  = (c == 2 || c == 7);
      latch_in = (c == 2) ? 8'h81 : (c == 7) ? 8'h12 : 8'h00;
      if (ctr_en) en_cnt++;
      if (evt_valid && evt_ready) got.push_back(evt_data);
      if (done) begin seen = 1; busy_at_done = busy; end
      else begin step(); c++; end
    end
    trig_in = 1'b0;
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL basic_done got=%0d exp=1", seen); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%h exp=0", busy_at_done); end
    total++; if (en_cnt != 10) begin bad++; $display("FAIL basic_ctr_en_cycles got=%0d exp=10", en_cnt); end
    total++; if (got.size() != 2) begin bad++; $display("FAIL basic_evt_count got=%0d exp=2", got.size()); end
    total++; if ((got.size() > 0 ? got[0] : 24'hx) !== {16'd2, 8'h81}) begin bad++; $display("FAIL basic_evt0 got=%h exp=%h", (got.size() > 0 ? got[0] : 24'hx), {16'd2, 8'h81}); end
    total++; if ((got.size() > 1 ? got[1] : 24'hx) !== {16'd7, 8'h12}) begin bad++; $display("FAIL basic_evt1 got=%h exp=%h", (got.size() > 1 ? got[1] : 24'hx), {16'd7, 8'h12}); end
    total++; if (drop_cnt !== 8'h0) begin bad++; $display("FAIL basic_drop_cnt got=%0d exp=0", drop_cnt); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%h exp=0", done); end
  endtask

  task automatic test_overflow();
    logic [23:0] got[$];
    logic [23:0] exp_w;
    int c = 0;
    bit seen = 0;
    evt_ready = 1'b0;
    go(16'd0);
    // 11 edges at even timestamps 0..20, latch 8'h10+k.
    for (int i = 0; i < 22; i++) begin
      trig_in  = (i % 2 == 0);
      latch_in = 8'(8'h10 + i / 2);
      step();
    end
    trig_in = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++; if (ctr_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ovf_drain ctr_en=%h busy=%h exp ctr_en=0 busy=1", ctr_en, busy); end
    total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL ovf_drop_cnt got=%0d exp=3", drop_cnt); end
    // Held head: data must not move while ready is low.
    step();
    total++; if (evt_data !== {16'd0, 8'h10}) begin bad++; $display("FAIL ovf_head_hold got=%h exp=%h", evt_data, {16'd0, 8'h10}); end
    evt_ready = 1'b1;
    while (!seen && c < 30) begin
      if (evt_valid && evt_ready) got.push_back(evt_data);
      if (done) seen = 1;
      else begin step(); c++; end
    end
    total++; if (got.size() != 8) begin bad++; $display("FAIL ovf_evt_count got=%0d exp=8", got.size()); end
    for (int k = 0; k < 8; k++) begin
      exp_w = {16'(2 * k), 8'(8'h10 + k)};
      total++; if ((got.size() > k ? got[k] : 24'hx) !== exp_w) begin bad++; $display("FAIL ovf_evt%0d got=%h exp=%h", k, (got.size() > k ? got[k] : 24'hx), exp_w); end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL ovf_done got=%0d exp=1", seen); end
  endtask

  task automatic test_full_simul();
    logic [23:0] got[$];
    int c = 0;
    bit seen = 0;
    evt_ready = 1'b0;
    go(16'd0);
    // 8 edges at timestamps 0..14 fill the FIFO.
    for (int i = 0; i < 16; i++) begin
      trig_in  = (i % 2 == 0);
      latch_in = 8'(8'h20 + i / 2);
      step();
    end
    // ts=16: edge with a pop in the same cycle.
    trig_in = 1'b1;
    latch_in = 8'h30;
    evt_ready = 1'b1;
    step();
    trig_in = 1'b0;
    evt_ready = 1'b0;
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL simul_drop_cnt got=%0d exp=0", drop_cnt); end
    total++; if (evt_data !== {16'd2, 8'h21}) begin bad++; $display("FAIL simul_head got=%h exp=%h", evt_data, {16'd2, 8'h21}); end
    step();
    // ts=18: with no pop this edge must drop, proving the FIFO stayed full.
    trig_in = 1'b1;
    latch_in = 8'h31;
    step();
    trig_in = 1'b0;
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL simul_still_full got=%0d exp=1", drop_cnt); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    evt_ready = 1'b1;
    while (!seen && c < 30) begin
      if (evt_valid && evt_ready) got.push_back(evt_data);
      if (done) seen = 1;
      else begin step(); c++; end
    end
    total++; if (got.size() != 8) begin bad++; $display("FAIL simul_evt_count got=%0d exp=8", got.size()); end
    total++; if ((got.size() > 7 ? got[7] : 24'hx) !== {16'd16, 8'h30}) begin bad++; $display("FAIL simul_last got=%h exp=%h", (got.size() > 7 ? got[7] : 24'hx), {16'd16, 8'h30}); end
  endtask

  task automatic test_held();
    logic [23:0] got[$];
    int c = 0;
    int en_cnt = 0;
    bit seen = 0;
    evt_ready = 1'b1;
    go(16'd20);
    while (!seen && c < 60) begin
      trig_in  = (c >= 3 && c <= 7);
      latch_in = 8'h55;
      start    = (c == 10);
      if (ctr_en) en_cnt++;
      if (evt_valid && evt_ready) got.push_back(evt_data);
      if (done) seen = 1;
      else begin step(); c++; end
    end
    trig_in = 1'b0;
    start = 1'b0;
    total++; if (got.size() != 1) begin bad++; $display("FAIL held_evt_count got=%0d exp=1", got.size()); end
    total++; if ((got.size() > 0 ? got[0] : 24'hx) !== {16'd3, 8'h55}) begin bad++; $display("FAIL held_evt0 got=%h exp=%h", (got.size() > 0 ? got[0] : 24'hx), {16'd3, 8'h55}); end
    total++; if (en_cnt != 20) begin bad++; $display("FAIL held_no_restart ctr_en_cycles got=%0d exp=20", en_cnt); end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL held_done got=%0d exp=1", seen); end
  endtask

  task automatic test_early_stop();
    logic [23:0] got[$];
    int c = 0;
    int en_cnt = 0;
    bit seen = 0;
    logic en_after = 1'bx;
    evt_ready = 1'b1;
    go(16'd100);
    while (!seen && c < 60) begin
      trig_in  = (c == 5 || c == 21);
      latch_in = (c == 5) ? 8'hA5 : 8'h5A;
      stop     = (c == 20);
      if (c == 21) en_after = ctr_en;
      if (ctr_en) en_cnt++;
      if (evt_valid && evt_ready) got.push_back(evt_data);
      if (done) seen = 1;
      else begin step(); c++; end
    end
    trig_in = 1'b0;
    stop = 1'b0;
    total++; if (en_after !== 1'b0) begin bad++; $display("FAIL stop_ctr_en_next got=%h exp=0", en_after); end
    total++; if (en_cnt != 21) begin bad++; $display("FAIL stop_ctr_en_cycles got=%0d exp=21", en_cnt); end
    total++; if (got.size() != 1) begin bad++; $display("FAIL stop_evt_count got=%0d exp=1", got.size()); end
    total++; if ((got.size() > 0 ? got[0] : 24'hx) !== {16'd5, 8'hA5}) begin bad++; $display("FAIL stop_evt0 got=%h exp=%h", (got.size() > 0 ? got[0] : 24'hx), {16'd5, 8'hA5}); end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL stop_done got=%0d exp=1", seen); end
    repeat (3) step();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL stop_no_late_capture got=%h exp=0", evt_valid); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] got[$];
    int c = 0;
    int en_cnt = 0;
    bit seen = 0;
    evt_ready = 1'b0;
    go(16'd0);
    for (int i = 0; i < 6; i++) begin
      trig_in  = (i == 0 || i == 2 || i == 4);
      latch_in = 8'(8'h40 + i);
      step();
    end
    trig_in = 1'b0;
    total++; if (evt_valid !== 1'b1 || ctr_en !== 1'b1) begin bad++; $display("FAIL rmid_pre evt_valid=%h ctr_en=%h exp 1/1", evt_valid, ctr_en); end
    rst_n = 1'b0;
    #1;
    total++; if (ctr_en !== 1'b0)    begin bad++; $display("FAIL rmid_ctr_en got=%h exp=0", ctr_en); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rmid_evt_valid got=%h exp=0", evt_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rmid_busy got=%h exp=0", busy); end
    total++; if (drop_cnt !== 8'h0)  begin bad++; $display("FAIL rmid_drop_cnt got=%h exp=0", drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    evt_ready = 1'b1;
    go(16'd8);
    while (!seen && c < 40) begin
      trig_in  = (c == 3);
      latch_in = 8'h77;
      if (ctr_en) en_cnt++;
      if (evt_valid && evt_ready) got.push_back(evt_data);
      if (done) seen = 1;
      else begin step(); c++; end
    end
    trig_in = 1'b0;
    total++; if (got.size() != 1) begin bad++; $display("FAIL rmid_evt_count got=%0d exp=1", got.size()); end
    total++; if ((got.size() > 0 ? got[0] : 24'hx) !== {16'd3, 8'h77}) begin bad++; $display("FAIL rmid_evt0 got=%h exp=%h", (got.size() > 0 ? got[0] : 24'hx), {16'd3, 8'h77}); end
    total++; if (en_cnt != 8) begin bad++; $display("FAIL rmid_ctr_en_cycles got=%0d exp=8", en_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_simul();
    test_held();
    test_early_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
